uart_rx_fifo_ctrl: RTL

//  Controller between the UART receiver and the RX sync_fifo instance.
//  - Pushes received bytes into the FIFO and pops them on host RBR reads.
//  - Generates the 16550 RX status and interrupt conditions:

---
 rtl/uart_rx_fifo_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// RX-side glue between the UART receiver and its sync_fifo: push/pop control,
// 16550 line-status bits (DR, OE) and the RDA / character-timeout interrupts.
module uart_rx_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int CNT_W      = 8,
    parameter int TOUT_CHARS = 4
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_rx_valid,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rbr_rd,
    input  logic                  i_lsr_rd,
    input  logic                  i_fifo_en,
    input  logic                  i_fifo_clr,
    input  logic [1:0]            i_trig_lvl,
    input  logic                  i_char_tick,
    output logic                  o_fifo_wren,
    output logic [DATA_WIDTH-1:0] o_fifo_wdata,
    output logic                  o_fifo_rden,
    input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
    input  logic                  i_fifo_empty,
    input  logic                  i_fifo_full,
    input  logic [CNT_W-1:0]      i_fifo_number,
    output logic                  o_fifo_rst,
    output logic [DATA_WIDTH-1:0] o_rbr_data,
    output logic                  o_rbr_valid,
    output logic                  o_data_ready,
    output logic                  o_overrun,
    output logic                  o_int_rda,
    output logic                  o_int_timeout
);

    localparam int TCNT_W = $clog2(TOUT_CHARS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_TIMEOUT
    } tout_state_t;

    tout_state_t       state_q, state_d;
    logic [TCNT_W-1:0] cnt_q, cnt_d;
    logic              fifo_en_d;
    logic              fifo_rst_q;
    logic              rden_d;
    logic              clr_evt;
    logic              hold_16450;
    logic              overrun_evt;
    logic              activity;
    logic [CNT_W-1:0]  trig_level;

    // Disabling the FIFO flushes it exactly like an explicit FCR clear.
    assign clr_evt     = i_fifo_clr | (fifo_en_d & ~i_fifo_en);
    assign hold_16450  = ~i_fifo_en & ~i_fifo_empty;
    assign overrun_evt = i_rx_valid & ~clr_evt & (i_fifo_full | hold_16450);

    assign o_fifo_wren   = i_rx_valid & ~i_fifo_full & ~hold_16450 & ~clr_evt & ~i_sys_rst;
    assign o_fifo_wdata  = i_rx_data;
    assign o_fifo_rden   = i_rbr_rd & ~i_fifo_empty & ~i_sys_rst;
    assign o_fifo_rst    = i_sys_rst | fifo_rst_q;
    assign o_int_timeout = (state_q == ST_TIMEOUT);
    assign activity      = o_fifo_wren | o_fifo_rden;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        trig_level = CNT_W'(1);
        if (i_fifo_en) begin
            case (i_trig_lvl)
                2'b00:   trig_level = CNT_W'(1);
                2'b01:   trig_level = CNT_W'(DATA_DEPTH / 4);
                2'b10:   trig_level = CNT_W'(DATA_DEPTH / 2);
                default: trig_level = CNT_W'(DATA_DEPTH - 2);
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr_evt) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (~i_fifo_empty & i_fifo_en) state_d = ST_COUNT;
                end
                ST_COUNT: begin
                    if (i_fifo_empty | ~i_fifo_en) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (activity) begin
                        cnt_d = '0;
                    end else if (i_char_tick) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == TCNT_W'(TOUT_CHARS - 1)) state_d = ST_TIMEOUT;
                    end
                end
                ST_TIMEOUT: begin
                    if (i_fifo_empty | ~i_fifo_en) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (activity) begin
                        state_d = ST_COUNT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            fifo_en_d    <= 1'b0;
            fifo_rst_q   <= 1'b0;
            rden_d       <= 1'b0;
            o_rbr_data   <= '0;
            o_rbr_valid  <= 1'b0;
            o_overrun    <= 1'b0;
            o_int_rda    <= 1'b0;
            o_data_ready <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
        end else begin
            fifo_en_d    <= i_fifo_en;
            fifo_rst_q   <= clr_evt;
            rden_d       <= o_fifo_rden & ~clr_evt;
            o_rbr_valid  <= rden_d & ~clr_evt;
            if (rden_d & ~clr_evt) o_rbr_data <= i_fifo_rdata;
            // A fresh overrun in the same cycle as the LSR read keeps the flag set.
            if (overrun_evt)   o_overrun <= 1'b1;
            else if (i_lsr_rd) o_overrun <= 1'b0;
            o_int_rda    <= (i_fifo_number >= trig_level);
            o_data_ready <= ~i_fifo_empty;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
